// File: rtl/centroid_pkg.sv
// rtl/centroid_pkg.sv - shared widths, state encoding, divider tag type and clamp helpers
package centroid_pkg;

    localparam int SUM_W = 28;
    localparam int CNT_W = 20;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_X,
        ISSUE_Y,
        WAIT,
        PUBLISH
    } state_t;

    typedef struct packed {
        logic valid;
        logic is_y;
    } tag_t;

    // Quotients too large for the output field saturate rather than wrap.
    function automatic logic [X_W-1:0] clamp_x(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:X_W]) ? {X_W{1'b1}} : q[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:Y_W]) ? {Y_W{1'b1}} : q[Y_W-1:0];
    endfunction

endpackage

// File: rtl/div_tag_pipe.sv
// rtl/div_tag_pipe.sv - tag shift register matching the divider latency
module div_tag_pipe
    import centroid_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic clock,
    input  logic reset,
    input  tag_t push_tag,
    output tag_t pop_tag
);

    tag_t stages_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            stages_q[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign pop_tag = stages_q[DEPTH-1];

endmodule

// File: rtl/centroid_div_sequencer.sv
// rtl/centroid_div_sequencer.sv - per-frame centroid divide sequencing through a shared divider
module centroid_div_sequencer
    import centroid_pkg::*;
#(
    parameter int DIV_LATENCY = 32,
    parameter int MIN_PIXELS  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [SUM_W-1:0] x_sum,
    input  logic [SUM_W-1:0] y_sum,
    input  logic [CNT_W-1:0] pixel_count,
    output logic [SUM_W-1:0] div_dividend,
    output logic [CNT_W-1:0] div_divisor,
    output logic             div_issue,
    input  logic             div_rfd,
    input  logic [SUM_W-1:0] div_quotient,
    output logic [X_W-1:0]   x_cent,
    output logic [Y_W-1:0]   y_cent,
    output logic             cent_found,
    output logic             cent_valid,
    output logic             busy,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [SUM_W-1:0] x_snap_q, x_snap_d;
    logic [SUM_W-1:0] y_snap_q, y_snap_d;
    logic [CNT_W-1:0] cnt_snap_q, cnt_snap_d;
    logic [SUM_W-1:0] x_res_q, x_res_d;
    logic [SUM_W-1:0] y_res_q, y_res_d;
    logic             got_x_q, got_x_d;
    logic             got_y_q, got_y_d;
    logic [X_W-1:0]   x_cent_q, x_cent_d;
    logic [Y_W-1:0]   y_cent_q, y_cent_d;
    logic             cent_found_q, cent_found_d;
    logic             cent_valid_q, cent_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    tag_t             push_tag;
    tag_t             pop_tag;

    div_tag_pipe #(
        .DEPTH (DIV_LATENCY)
    ) u_tag_pipe (
        .clock    (clock),
        .reset    (reset),
        .push_tag (push_tag),
        .pop_tag  (pop_tag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            x_snap_q     <= '0;
            y_snap_q     <= '0;
            cnt_snap_q   <= '0;
            x_res_q      <= '0;
            y_res_q      <= '0;
            got_x_q      <= 1'b0;
            got_y_q      <= 1'b0;
            x_cent_q     <= '0;
            y_cent_q     <= '0;
            cent_found_q <= 1'b0;
            cent_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_snap_q     <= x_snap_d;
            y_snap_q     <= y_snap_d;
            cnt_snap_q   <= cnt_snap_d;
            x_res_q      <= x_res_d;
            y_res_q      <= y_res_d;
            got_x_q      <= got_x_d;
            got_y_q      <= got_y_d;
            x_cent_q     <= x_cent_d;
            y_cent_q     <= y_cent_d;
            cent_found_q <= cent_found_d;
            cent_valid_q <= cent_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_snap_d     = x_snap_q;
        y_snap_d     = y_snap_q;
        cnt_snap_d   = cnt_snap_q;
        x_res_d      = x_res_q;
        y_res_d      = y_res_q;
        got_x_d      = got_x_q;
        got_y_d      = got_y_q;
        x_cent_d     = x_cent_q;
        y_cent_d     = y_cent_q;
        cent_found_d = cent_found_q;
        cent_valid_d = 1'b0;
        busy_d       = busy_q;
        overrun_d    = frame_start && (state_q != IDLE);
        push_tag     = '0;
        div_issue    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;

        if (pop_tag.valid) begin
            if (pop_tag.is_y) begin
                y_res_d = div_quotient;
                got_y_d = 1'b1;
            end else begin
                x_res_d = div_quotient;
                got_x_d = 1'b1;
            end
        end

        // Output registers load on the edge entering PUBLISH so the strobe lines up with that state.
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    x_snap_d   = x_sum;
                    y_snap_d   = y_sum;
                    cnt_snap_d = pixel_count;
                    got_x_d    = 1'b0;
                    got_y_d    = 1'b0;
                    if (pixel_count < CNT_W'(MIN_PIXELS)) begin
                        state_d      = PUBLISH;
                        cent_found_d = 1'b0;
                        cent_valid_d = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        state_d = ISSUE_X;
                        busy_d  = 1'b1;
                    end
                end
            end
            ISSUE_X: begin
                div_issue    = 1'b1;
                div_dividend = x_snap_q;
                div_divisor  = cnt_snap_q;
                if (div_rfd) begin
                    push_tag.valid = 1'b1;
                    state_d        = ISSUE_Y;
                end
            end
            ISSUE_Y: begin
                div_issue    = 1'b1;
                div_dividend = y_snap_q;
                div_divisor  = cnt_snap_q;
                if (div_rfd) begin
                    push_tag.valid = 1'b1;
                    push_tag.is_y  = 1'b1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (got_x_d && got_y_d) begin
                    state_d      = PUBLISH;
                    x_cent_d     = clamp_x(x_res_d);
                    y_cent_d     = clamp_y(y_res_d);
                    cent_found_d = 1'b1;
                    cent_valid_d = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x_cent     = x_cent_q;
    assign y_cent     = y_cent_q;
    assign cent_found = cent_found_q;
    assign cent_valid = cent_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_centroid_div_sequencer.sv
// tb/tb_centroid_div_sequencer.sv - scoreboard bench for centroid_div_sequencer
module tb_centroid_div_sequencer;
    import centroid_pkg::*;

    localparam int L = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             frame_start = 1'b0;
    logic [SUM_W-1:0] x_sum = '0;
    logic [SUM_W-1:0] y_sum = '0;
    logic [CNT_W-1:0] pixel_count = '0;
    logic [SUM_W-1:0] div_dividend;
    logic [CNT_W-1:0] div_divisor;
    logic             div_issue;
    logic             div_rfd = 1'b1;
    logic [SUM_W-1:0] div_quotient;
    logic [X_W-1:0]   x_cent;
    logic [Y_W-1:0]   y_cent;
    logic             cent_found;
    logic             cent_valid;
    logic             busy;
    logic             overrun;

    typedef struct {
        longint x;
        longint y;
        longint found;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_valid = 0;
    longint last_x = 0;
    longint last_y = 0;

    centroid_div_sequencer #(
        .DIV_LATENCY (L),
        .MIN_PIXELS  (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .x_sum        (x_sum),
        .y_sum        (y_sum),
        .pixel_count  (pixel_count),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_issue    (div_issue),
        .div_rfd      (div_rfd),
        .div_quotient (div_quotient),
        .x_cent       (x_cent),
        .y_cent       (y_cent),
        .cent_found   (cent_found),
        .cent_valid   (cent_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference divider: quotient appears L cycles after an accepted issue.
    logic [SUM_W-1:0] qpipe [L];
    always @(posedge clock) begin
        qpipe[0] <= (div_issue && div_rfd && div_divisor != 0) ? div_dividend / SUM_W'(div_divisor) : '0;
        for (int i = 1; i < L; i++) qpipe[i] <= qpipe[i-1];
    end
    assign div_quotient = qpipe[L-1];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (cent_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("cent_x", x_cent, mon_e.x);
                check_eq("cent_y", y_cent, mon_e.y);
                check_eq("cent_found", cent_found, mon_e.found);
                check_eq("cent_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input longint xs, input longint ys, input longint n, input int stall);
        exp_t   e;
        longint qx;
        longint qy;
        if (n < 16) begin
            e.x     = last_x;
            e.y     = last_y;
            e.found = 0;
            e.cyc   = cyc + 1;
        end else begin
            qx      = xs / n;
            qy      = ys / n;
            e.x     = (qx > 2047) ? 2047 : qx;
            e.y     = (qy > 1023) ? 1023 : qy;
            e.found = 1;
            e.cyc   = cyc + 3 + L + stall;
            last_x  = e.x;
            last_y  = e.y;
        end
        sb.push_back(e);
        x_sum       = SUM_W'(xs);
        y_sum       = SUM_W'(ys);
        pixel_count = CNT_W'(n);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        check_eq("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     c0;
        int     nv;
        longint sat_x [3] = '{134217728, 40960, 40940};
        longint sat_y [3] = '{1048576, 20460, 20440};
        longint sat_n [3] = '{16, 20, 20};

        repeat (3) step();
        check_eq("rst_x_cent", x_cent, 0);
        check_eq("rst_y_cent", y_cent, 0);
        check_eq("rst_found", cent_found, 0);
        check_eq("rst_valid", cent_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_issue", div_issue, 0);
        check_eq("rst_dividend", div_dividend, 0);
        reset = 1'b0;
        step();

        // Nominal divide path.
        start_frame(5000, 3000, 50, 0);
        check_eq("a_issue_x", div_issue, 1);
        check_eq("a_dividend_x", div_dividend, 5000);
        check_eq("a_divisor", div_divisor, 50);
        check_eq("a_busy", busy, 1);
        step();
        check_eq("a_issue_y", div_issue, 1);
        check_eq("a_dividend_y", div_dividend, 3000);
        step();
        check_eq("a_issue_off", div_issue, 0);
        check_eq("a_dividend_off", div_dividend, 0);
        wait_idle(100);
        check_eq("a_busy_after", busy, 0);

        // Low pixel count bypasses the divider and keeps the previous centroid.
        start_frame(900, 900, 10, 0);
        check_eq("b_no_issue", div_issue, 0);
        check_eq("b_busy", busy, 0);
        wait_idle(10);

        // Divider back-pressure for three cycles in ISSUE_X.
        div_rfd = 1'b0;
        start_frame(7000, 2500, 100, 3);
        check_eq("c_issue_hold1", div_issue, 1);
        check_eq("c_dividend_hold1", div_dividend, 7000);
        step();
        check_eq("c_dividend_hold2", div_dividend, 7000);
        step();
        check_eq("c_dividend_hold3", div_dividend, 7000);
        check_eq("c_divisor_hold3", div_divisor, 100);
        step();
        div_rfd = 1'b1;
        check_eq("c_issue_x4", div_issue, 1);
        check_eq("c_dividend_x4", div_dividend, 7000);
        step();
        check_eq("c_dividend_y5", div_dividend, 2500);
        wait_idle(100);

        // Saturation and clamp boundaries.
        for (int i = 0; i < 3; i++) begin
            start_frame(sat_x[i], sat_y[i], sat_n[i], 0);
            wait_idle(100);
        end

        // frame_start while busy is ignored and flagged.
        c0 = cyc;
        start_frame(6000, 4000, 60, 0);
        step_to(c0 + 10);
        x_sum       = 1;
        y_sum       = 1;
        pixel_count = 100;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_eq("ovr_pulse", overrun, 1);
        check_eq("ovr_busy", busy, 1);
        step();
        check_eq("ovr_clear", overrun, 0);
        wait_idle(100);

        // Reset mid-operation discards the in-flight frame.
        c0 = cyc;
        start_frame(9000, 9000, 90, 0);
        step_to(c0 + 20);
        reset = 1'b1;
        step();
        check_eq("mid_rst_x_cent", x_cent, 0);
        check_eq("mid_rst_y_cent", y_cent, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_issue", div_issue, 0);
        reset = 1'b0;
        sb.delete();
        last_x = 0;
        last_y = 0;
        nv = n_valid;
        step_to(c0 + 40);
        check_eq("mid_rst_no_valid", n_valid - nv, 0);
        start_frame(3300, 1100, 33, 0);
        wait_idle(100);

        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
